seq_detect_arbiter: RTL



---
 rtl/seq_detect_arbiter_pkg.sv | 33 +++
 rtl/seq_detect_arbiter_if.sv | 39 +++
 rtl/seq_detect_arbiter_detector.sv | 45 ++++
 rtl/seq_detect_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seq_detect_arbiter_pkg.sv
// Shared types, default constants and the round-robin pick helper for seq_detect_arbiter.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int              DEF_PAT_W     = 5;
    localparam logic [4:0]      DEF_PATTERN   = 5'b10011;
    localparam int              DEF_FRAME_LEN = 16;

    // First requester at or after ptr, wrapping modulo nreq; returns ptr when nothing requests.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         nreq);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = 3'((int'(ptr) + i) % nreq);
            if (!found && (i < nreq) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Requester/event bus of seq_detect_arbiter; cnt_sel/cnt_out exist only with SEQDET_MATCH_COUNT_EN.
interface seq_detect_arbiter_if
    import seqdet_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] bit_in;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            Z;
    logic [ID_W-1:0] match_id;
    logic            frame_done;
    logic            frame_hit;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [ID_W-1:0] cnt_sel;
    logic [7:0]      cnt_out;
`endif

    modport master (
        output req, bit_in,
        input  gnt, busy, Z, match_id, frame_done, frame_hit
`ifdef SEQDET_MATCH_COUNT_EN
        , output cnt_sel
        , input  cnt_out
`endif
    );

    modport slave (
        input  req, bit_in,
        output gnt, busy, Z, match_id, frame_done, frame_hit
`ifdef SEQDET_MATCH_COUNT_EN
        , input  cnt_sel
        , output cnt_out
`endif
    );

endinterface

// File: rtl/seq_detect_arbiter_detector.sv
// PAT_W-bit window detector: shifts in one bit per enable, pulses hit one cycle after a full-window match.
module seq_window_detector
    import seqdet_pkg::*;
#(
    parameter int              PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic shift_en_i,
    input  logic bit_i,
    output logic hit_o
);
    localparam int GW = $clog2(PAT_W);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [GW-1:0]    fill_q;
    logic             full;

    assign hist_d = {hist_q[PAT_W-2:0], bit_i};
    // fill_q saturates once PAT_W-1 earlier bits are in, so zeros from the clear never match
    assign full   = (fill_q == GW'(PAT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            hit_o  <= 1'b0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
            hit_o  <= 1'b0;
        end else if (shift_en_i) begin
            hist_q <= hist_d;
            hit_o  <= (hist_d == PATTERN) && full;
            if (!full)
                fill_q <= fill_q + 1'b1;
        end else begin
            hit_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter sharing one serial pattern detector among NREQ streams, one FRAME_LEN window per grant.
// Optional per-channel saturating match counters are built when SEQDET_MATCH_COUNT_EN is defined.
module seq_detect_arbiter
    import seqdet_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               ID_W      = 2,
    parameter int               PAT_W     = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN   = DEF_PATTERN,
    parameter int               FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    seq_detect_arbiter_if.slave  bus
);
    localparam int         FC_W     = $clog2(FRAME_LEN);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] sel_q, sel_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [FC_W-1:0] left_q, left_d;
    logic            seen_q, seen_d;
    logic [ID_W-1:0] last_id_q;
    logic [ID_W-1:0] pick;
    logic            det_clr, det_shift, det_hit;
    logic            cur_bit, req_sel;

    assign pick    = ID_W'(rr_pick(8'(bus.req), 3'(ptr_q), NREQ));
    assign cur_bit = bus.bit_in[sel_q];
    assign req_sel = bus.req[sel_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        left_d    = left_q;
        seen_d    = seen_q;
        det_clr   = 1'b0;
        det_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    sel_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    ptr_d       = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
                    left_d      = FC_W'(FRAME_LEN - 1);
                    seen_d      = 1'b0;
                    det_clr     = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                seen_d = seen_q | det_hit;
                if (!req_sel) begin
                    gnt_d   = '0;
                    det_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    det_shift = 1'b1;
                    left_d    = left_q - 1'b1;
                    if (left_q == '0) begin
                        gnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            left_q    <= '0;
            seen_q    <= 1'b0;
            last_id_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            seen_q  <= seen_d;
            if (det_hit)
                last_id_q <= sel_q;
        end
    end

    seq_window_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_det (
        .clk        (CLK),
        .rst_n      (RST),
        .clr_i      (det_clr),
        .shift_en_i (det_shift),
        .bit_i      (cur_bit),
        .hit_o      (det_hit)
    );

    // sel_q is stable from grant until the next grant, so it names the channel while Z is high
    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.Z          = det_hit;
    assign bus.match_id   = det_hit ? sel_q : last_id_q;
    assign bus.frame_done = (state_q == ST_DONE);
    assign bus.frame_hit  = (state_q == ST_DONE) && (seen_q || det_hit);

`ifdef SEQDET_MATCH_COUNT_EN
    logic [7:0] cnt_q [NREQ];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREQ; i++)
                cnt_q[i] <= '0;
        end else if (det_hit && (cnt_q[sel_q] != 8'hFF)) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
        end
    end

    assign bus.cnt_out = (int'(bus.cnt_sel) < NREQ) ? cnt_q[bus.cnt_sel] : 8'h00;
`endif

endmodule
